// File: rtl/small_lpf_mc.sv
// small_lpf_mc: time-multiplexed cascade of single-pole IIR low-pass sections.
// Each stage performs y += (x - y) >>> shift on per-channel state kept in
// register arrays, so one datapath serves CHANNELS interleaved streams.
// Pipe slot 0 is the input register; slot k holds the result of stage k, and
// slot STAGES doubles as the output register (latency STAGES+1 edges).
// Optional feature macro: SMALL_LPF_MC_ROUND_EN selects round-half-up with
// positive saturation for stage outputs; when undefined, outputs use floor.
module small_lpf_mc #(
  parameter int WIDTH     = 8,
  parameter int FILT_BITS = 5,
  parameter int STAGES    = 2,
  parameter int CHANNELS  = 4,
  parameter int CH_BITS   = 2,
  parameter int SH_BITS   = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      inValid,
  input  logic [CH_BITS-1:0]        inChan,
  input  logic [SH_BITS-1:0]        shift,
  input  logic signed [WIDTH-1:0]   dataIn,
  input  logic                      clr,
  input  logic [CH_BITS-1:0]        clrChan,
  output logic                      outValid,
  output logic [CH_BITS-1:0]        outChan,
  output logic signed [WIDTH-1:0]   dataOut
);

  localparam int ACC_W = WIDTH + FILT_BITS;
  localparam int D_W   = ACC_W + 1;

  // Pipe slots 0..STAGES: sample valid, channel, clamped shift, sample value.
  logic                       vld_q [STAGES+1];
  logic                       vld_d [STAGES+1];
  logic [CH_BITS-1:0]         chn_q [STAGES+1];
  logic [CH_BITS-1:0]         chn_d [STAGES+1];
  logic [SH_BITS-1:0]         sh_q  [STAGES+1];
  logic [SH_BITS-1:0]         sh_d  [STAGES+1];
  logic signed [WIDTH-1:0]    dat_q [STAGES+1];
  logic signed [WIDTH-1:0]    dat_d [STAGES+1];

  // Per-stage, per-channel filter state, scaled by 2^FILT_BITS.
  logic signed [ACC_W-1:0]    acc_q [STAGES][CHANNELS];
  logic signed [ACC_W-1:0]    acc_d [STAGES][CHANNELS];

  // Updated state word produced by each stage this cycle.
  logic signed [ACC_W-1:0]    upd_acc [STAGES];
  logic                       clr_hit;

  // True when a channel index addresses an existing channel.
  function automatic logic ch_ok(input logic [CH_BITS-1:0] c);
    return (32'(c) < 32'(CHANNELS));
  endfunction

  // One single-pole update: acc + ((x << FILT_BITS) - acc) >>> sh.
  // The difference is carried one bit wider so it cannot wrap; the sum is a
  // convex combination of acc and x, so it always fits back into ACC_W bits.
  function automatic logic signed [ACC_W-1:0] stage_acc(
    input logic signed [WIDTH-1:0] x,
    input logic signed [ACC_W-1:0] a,
    input logic [SH_BITS-1:0]      sh
  );
    logic signed [D_W-1:0] xs;
    logic signed [D_W-1:0] as_w;
    logic signed [D_W-1:0] diff;
    logic signed [D_W-1:0] sum;
    xs   = {{(D_W-WIDTH){x[WIDTH-1]}}, x};
    xs   = xs <<< FILT_BITS;
    as_w = {a[ACC_W-1], a};
    diff = xs - as_w;
    sum  = as_w + (diff >>> sh);
    return sum[ACC_W-1:0];
  endfunction

`ifdef SMALL_LPF_MC_ROUND_EN
  localparam logic [D_W-1:0] HALF_LSB = D_W'(1) << (FILT_BITS - 1);

  // Round half up to WIDTH bits; only the positive end can overflow.
  function automatic logic signed [WIDTH-1:0] stage_out(
    input logic signed [ACC_W-1:0] a
  );
    logic [D_W-1:0] r;
    r = {a[ACC_W-1], a} + HALF_LSB;
    if (r[D_W-1] != r[D_W-2]) begin
      return {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      return r[D_W-2:FILT_BITS];
    end
  endfunction
`else
  // Floor: drop the fractional bits of the state word.
  function automatic logic signed [WIDTH-1:0] stage_out(
    input logic signed [ACC_W-1:0] a
  );
    return a[ACC_W-1:FILT_BITS];
  endfunction
`endif

  // Input capture, stage read-modify-write, pipe advance and channel clear.
  always_comb begin
    vld_d[0] = inValid && ch_ok(inChan);
    chn_d[0] = inChan;
    sh_d[0]  = (shift > SH_BITS'(FILT_BITS)) ? SH_BITS'(FILT_BITS) : shift;
    dat_d[0] = dataIn;
    acc_d    = acc_q;

    for (int k = 1; k <= STAGES; k++) begin
      upd_acc[k-1] = stage_acc(dat_q[k-1], acc_q[k-1][chn_q[k-1]], sh_q[k-1]);
      vld_d[k]     = vld_q[k-1];
      chn_d[k]     = chn_q[k-1];
      sh_d[k]      = sh_q[k-1];
      dat_d[k]     = stage_out(upd_acc[k-1]);
      // Invalid slots leave the state untouched.
      acc_d[k-1][chn_q[k-1]] = vld_q[k-1] ? upd_acc[k-1]
                                          : acc_q[k-1][chn_q[k-1]];
    end

    // The clear is applied last so it wins over a same-edge sample write;
    // that sample still carries its computed value down the pipe.
    clr_hit = clr && ch_ok(clrChan);
    for (int s = 0; s < STAGES; s++) begin
      acc_d[s][clrChan] = clr_hit ? {ACC_W{1'b0}} : acc_d[s][clrChan];
    end
  end

  // State and pipe registers: synchronous reset, otherwise advance when enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= STAGES; i++) begin
        vld_q[i] <= 1'b0;
        chn_q[i] <= {CH_BITS{1'b0}};
        sh_q[i]  <= {SH_BITS{1'b0}};
        dat_q[i] <= {WIDTH{1'b0}};
      end
      for (int s = 0; s < STAGES; s++) begin
        for (int c = 0; c < CHANNELS; c++) begin
          acc_q[s][c] <= {ACC_W{1'b0}};
        end
      end
    end else if (en) begin
      vld_q <= vld_d;
      chn_q <= chn_d;
      sh_q  <= sh_d;
      dat_q <= dat_d;
      acc_q <= acc_d;
    end
  end

  assign outValid = vld_q[STAGES];
  assign outChan  = chn_q[STAGES];
  assign dataOut  = dat_q[STAGES];

endmodule

// File: tb/tb_small_lpf_mc.sv
// tb_small_lpf_mc: randomized scoreboard bench for small_lpf_mc.
// The reference model keeps integer filter state per stage/channel and a
// queue of in-flight samples; each enabled edge advances every in-flight
// sample by one stage. Finished samples are pushed to an expected queue that
// a negedge monitor pops whenever the DUT presents outValid.
module tb_small_lpf_mc;

  localparam int WIDTH     = 8;
  localparam int FILT_BITS = 5;
  localparam int STAGES    = 2;
  localparam int CHANNELS  = 4;
  localparam int CH_BITS   = 2;
  localparam int SH_BITS   = 3;

  logic                    clk = 1'b0;
  logic                    rst, en, inValid, clr;
  logic [CH_BITS-1:0]      inChan, clrChan;
  logic [SH_BITS-1:0]      shift;
  logic signed [WIDTH-1:0] dataIn;
  logic                    outValid;
  logic [CH_BITS-1:0]      outChan;
  logic signed [WIDTH-1:0] dataOut;

  always #5 clk = ~clk;

  small_lpf_mc #(
    .WIDTH(WIDTH), .FILT_BITS(FILT_BITS), .STAGES(STAGES),
    .CHANNELS(CHANNELS), .CH_BITS(CH_BITS), .SH_BITS(SH_BITS)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .inValid(inValid), .inChan(inChan),
    .shift(shift), .dataIn(dataIn), .clr(clr), .clrChan(clrChan),
    .outValid(outValid), .outChan(outChan), .dataOut(dataOut)
  );

  typedef struct { int ch; int sh; int x; int stg; } flight_t;
  typedef struct { int ch; int val; } exp_t;

  int      acc_m [STAGES][CHANNELS];
  flight_t fl[$];
  exp_t    exq[$];

  int errors = 0;
  int checks = 0;
  bit started = 1'b0;
  bit last_en = 1'b0;
  bit last_rst = 1'b1;
  bit step_mode = 1'b0;
  int step_prev = 0;
  bit prev_v;
  int prev_ch, prev_d;

  // Stage output from a scaled state value.
  function automatic int m_out(int a);
    int r;
`ifdef SMALL_LPF_MC_ROUND_EN
    r = (a + (1 << (FILT_BITS - 1))) >>> FILT_BITS;
    if (r > 127) r = 127;
`else
    r = a >>> FILT_BITS;
`endif
    return r;
  endfunction

  // Reference behaviour of one clock edge.
  task automatic model_edge(input bit r, input bit e, input bit v, input int ch,
                            input int sh, input int x, input bit c, input int cch);
    int a;
    last_rst = r;
    last_en  = e;
    started  = 1'b1;
    if (r) begin
      for (int s = 0; s < STAGES; s++)
        for (int k = 0; k < CHANNELS; k++) acc_m[s][k] = 0;
      fl.delete();
      exq.delete();
    end else if (e) begin
      for (int i = 0; i < fl.size(); i++) begin
        a = acc_m[fl[i].stg-1][fl[i].ch];
        a = a + ((fl[i].x * (1 << FILT_BITS) - a) >>> fl[i].sh);
        acc_m[fl[i].stg-1][fl[i].ch] = a;
        fl[i].x = m_out(a);
        fl[i].stg = fl[i].stg + 1;
      end
      if (fl.size() > 0 && fl[0].stg > STAGES) begin
        exq.push_back('{ch: fl[0].ch, val: fl[0].x});
        void'(fl.pop_front());
      end
      if (c && cch < CHANNELS)
        for (int s = 0; s < STAGES; s++) acc_m[s][cch] = 0;
      if (v && ch < CHANNELS)
        fl.push_back('{ch: ch, sh: (sh > FILT_BITS) ? FILT_BITS : sh, x: x, stg: 1});
    end
  endtask

  // Apply one cycle of stimulus and advance the model on the same edge.
  task automatic drive(input bit v, input int ch, input int sh, input int x,
                       input bit c, input int cch, input bit e, input bit r);
    inValid = v;
    inChan  = CH_BITS'(ch);
    shift   = SH_BITS'(sh);
    dataIn  = WIDTH'(x);
    clr     = c;
    clrChan = CH_BITS'(cch);
    en      = e;
    rst     = r;
    @(posedge clk);
    model_edge(r, e, v, ch, sh, x, c, cch);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 0, 1'b0, 0, 1'b1, 1'b0);
  endtask

  // Monitor: compare DUT outputs against the scoreboard after every edge.
  always @(negedge clk) begin
    if (started) begin
      if (last_rst) begin
        checks++;
        if (outValid !== 1'b0 || outChan !== '0 || dataOut !== '0) begin
          errors++;
          $display("FAIL reset_out: got v=%0b ch=%0d d=%0d, want v=0 ch=0 d=0",
                   outValid, outChan, dataOut);
        end
      end else if (!last_en) begin
        checks++;
        if (outValid !== prev_v || int'(outChan) != prev_ch || int'(dataOut) != prev_d) begin
          errors++;
          $display("FAIL frozen_out: got v=%0b ch=%0d d=%0d, want v=%0b ch=%0d d=%0d",
                   outValid, outChan, dataOut, prev_v, prev_ch, prev_d);
        end
      end else if (outValid === 1'b1) begin
        checks++;
        if (exq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out: got ch=%0d d=%0d, want no output",
                   outChan, dataOut);
        end else begin
          exp_t ex;
          ex = exq.pop_front();
          if (int'(outChan) != ex.ch || int'(dataOut) != ex.val) begin
            errors++;
            $display("FAIL sample: got ch=%0d d=%0d, want ch=%0d d=%0d",
                     outChan, dataOut, ex.ch, ex.val);
          end
          if (step_mode) begin
            checks++;
            if (int'(dataOut) < step_prev || int'(dataOut) > 100) begin
              errors++;
              $display("FAIL step_monotonic: got %0d, want between %0d and 100",
                       dataOut, step_prev);
            end
            step_prev = int'(dataOut);
          end
        end
      end else begin
        checks++;
        if (outValid !== 1'b0 || exq.size() != 0) begin
          errors++;
          $display("FAIL missing_out: got v=%b, want %0d pending output(s)",
                   outValid, exq.size());
        end
      end
      prev_v  = outValid;
      prev_ch = int'(outChan);
      prev_d  = int'(dataOut);
    end
  end

  initial begin
    int ch, x;
    inValid = 1'b0; inChan = '0; shift = '0; dataIn = '0;
    clr = 1'b0; clrChan = '0; en = 1'b1; rst = 1'b1;

    // Reset.
    for (int i = 0; i < 3; i++) drive(1'b0, 0, 0, 0, 1'b0, 0, 1'b1, 1'b1);

    // Step response on ch0, shift 5.
    step_mode = 1'b1;
    for (int i = 0; i < 60; i++) drive(1'b1, 0, 5, 100, 1'b0, 0, 1'b1, 1'b0);
    idle(STAGES + 1);
    step_mode = 1'b0;

    // Pass-through with shift 0 on random channels.
    for (int i = 0; i < 30; i++)
      drive(1'b1, $urandom_range(0, 3), 0, $urandom_range(0, 255) - 128,
            1'b0, 0, 1'b1, 1'b0);

    // Channel isolation: ch1 at -128, ch2 at +127, then probe ch0 and ch3.
    for (int i = 0; i < 60; i++)
      drive(1'b1, (i % 2 == 0) ? 1 : 2, 1, (i % 2 == 0) ? -128 : 127,
            1'b0, 0, 1'b1, 1'b0);
    drive(1'b1, 0, 5, 0, 1'b0, 0, 1'b1, 1'b0);
    drive(1'b1, 3, 5, 0, 1'b0, 0, 1'b1, 1'b0);

    // Clear collisions on ch1 at the capture, stage-1 and stage-2 edges.
    drive(1'b1, 1, 2, 50, 1'b1, 1, 1'b1, 1'b0);
    drive(1'b0, 0, 0, 0, 1'b1, 1, 1'b1, 1'b0);
    drive(1'b0, 0, 0, 0, 1'b1, 1, 1'b1, 1'b0);
    drive(1'b1, 1, 1, 64, 1'b0, 0, 1'b1, 1'b0);
    idle(STAGES + 1);

    // Enable low for 10 cycles mid-stream; inputs during the gap are ignored.
    for (int i = 0; i < 6; i++)
      drive(1'b1, $urandom_range(0, 3), 3, $urandom_range(0, 255) - 128,
            1'b0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++)
      drive(1'b1, $urandom_range(0, 3), 2, $urandom_range(0, 255) - 128,
            1'b1, $urandom_range(0, 3), 1'b0, 1'b0);
    for (int i = 0; i < 6; i++)
      drive(1'b1, $urandom_range(0, 3), 3, $urandom_range(0, 255) - 128,
            1'b0, 0, 1'b1, 1'b0);

    // Reset while samples are in flight, then a zero sample.
    drive(1'b1, 2, 1, 90, 1'b0, 0, 1'b1, 1'b0);
    drive(1'b1, 3, 1, -90, 1'b0, 0, 1'b1, 1'b1);
    ch = $urandom_range(0, 3);
    drive(1'b1, ch, $urandom_range(0, 7), 0, 1'b0, 0, 1'b1, 1'b0);
    idle(STAGES + 1);

    // Randomized traffic with sporadic clears and enable gaps.
    for (int i = 0; i < 400; i++) begin
      x = $urandom_range(0, 255) - 128;
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 7), x,
            $urandom_range(0, 15) == 0, $urandom_range(0, 3),
            $urandom_range(0, 7) != 0, 1'b0);
    end
    idle(STAGES + 2);

    @(negedge clk);
    checks++;
    if (exq.size() != 0 || fl.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d expected and %0d in-flight left, want 0",
               exq.size(), fl.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
